axi_read_master: RTL and testbench
==================================

AXI_READ_MASTER -- requirements
Module: axi_read_master

Interface
REQ-001 Param DATA_WIDTH, default 32, AXI data bus width in bits (multiple of 8).
REQ-002 Param ADDRESS_WIDTH, default 8, AXI byte-address width.
REQ-003 Param STROBE_WIDTH, default DATA_WIDTH/8, bytes per bus word.
REQ-004 Clocking: one clock; reset asynchronous and active-high.
REQ-005 aclk  in  1  sole clock; all state changes on rising edge.
REQ-006 areset  in  1  asynchronous active-high reset.
REQ-007 cmd_addr  in  ADDRESS_WIDTH  burst start byte address.
REQ-008 cmd_len  in  8  AXI length (beats = cmd_len+1).
REQ-009 cmd_size  in  3  AXI size (bytes per beat = 2**cmd_size).
REQ-010 cmd_valid / cmd_ready  in / out  1  command handshake.
REQ-011 araddr, arlen, arsize, arburst  out  ADDRESS_WIDTH, 8, 3, 2  read address channel; arburst fixed 2'b01 (INCR).
REQ-012 arvalid / arready  out / in  1  read address handshake.
REQ-013 rdata, rresp, rlast, rvalid  in  DATA_WIDTH, 2, 1, 1  read data channel; rready  out  1.
REQ-014 out_data  out  DATA_WIDTH  beat's valid bytes, right-justified, upper bytes zero.
REQ-015 out_last, out_valid  out  1; out_ready  in  1  output stream handshake.
REQ-016 resp_err, last_err, size_err  out  1  sticky error flags.

Function
REQ-017 States IDLE, ADDR, DATA; cmd_ready = (state==IDLE); arvalid = (state==ADDR).
REQ-018 IDLE, cmd_valid=1, cmd_size<=log2(STROBE_WIDTH): register cmd fields, clear all error flags, beats_remaining=cmd_len+1 (9 bits), beat_n=1, -> ADDR.
REQ-019 IDLE, cmd_valid=1, cmd_size>log2(STROBE_WIDTH): accept command, set size_err, issue no AR, remain IDLE.
REQ-020 ADDR: araddr/arlen/arsize held stable from registered command until arready; arvalid&&arready -> DATA next cycle.
REQ-021 DATA: rready = !out_valid || out_ready (one-entry output register, no data loss, no bubble under continuous out_ready).
REQ-022 Beat accepted on rvalid&&rready: load out_data, out_valid<=1, out_last<=(beats_remaining==1), beats_remaining--, beat_n++, cur_addr<=aligned+beat_n*bytes.
REQ-023 aligned = (cmd_addr>>size)<<size; lower_lane = cur_addr mod STROBE_WIDTH; upper_lane = first beat ? (aligned mod STROBE_WIDTH)+bytes-1 : lower_lane+bytes-1.
REQ-024 out_data = rdata lanes lower_lane..upper_lane shifted down to bit 0; all other bits 0.
REQ-025 Address arithmetic wraps modulo 2**ADDRESS_WIDTH; no 4KB-boundary check.
REQ-026 Final beat (beats_remaining==1) accepted -> IDLE same edge; new command may start while last beat still in output register.
REQ-027 out_valid cleared when out_ready=1 and no new beat loaded that cycle; simultaneous drain and load keeps out_valid=1.
REQ-028 rresp!=0 on any beat: set resp_err; data still forwarded, burst continues.
REQ-029 rlast value != (beats_remaining==1) on an accepted beat: set last_err; completion governed by counter only.
REQ-030 rvalid while not DATA is ignored (rready=0).

Reset
REQ-031 areset=1: immediately state=IDLE, arvalid=0, rready=0, out_valid=0, out_last=0, out_data=0, all error flags 0, araddr/arlen/arsize=0; cmd_ready=1.
REQ-032 Reset mid-burst abandons outstanding beats; no output after release until new command.

Verification
REQ-033 Slave RAM byte i = i, cmd addr 0x10 len 3 size 2 -> out_data 0x13121110, 0x17161514, 0x1B1A1918, 0x1F1E1D1C; out_last only on 4th.
REQ-034 cmd addr 0x06 len 1 size 2 (unaligned) -> out_data 0x00000706 then 0x0B0A0908.
REQ-035 cmd addr 0x05 len 1 size 0 -> out_data 0x00000005 then 0x00000006, out_last on 2nd.
REQ-036 out_ready held 0 for 5 cycles mid-burst -> rready 0 after one buffered beat, all 4 beats delivered in order, none lost.
REQ-037 rresp=2'b10 on beat 2 and rlast early on beat 3 of 4 -> resp_err=1, last_err=1, 4 beats still delivered; flags cleared on next command.
REQ-038 areset pulsed during beat 2 -> arvalid, rready, out_valid 0 same cycle; cmd_ready=1; cmd_size=3 on 32-bit bus -> size_err=1, no arvalid.

Source files
------------

// File: rtl/axi_read_master.sv
// AXI4 read master: one INCR burst per command, each beat's valid
// bytes right-justified into a one-entry output register.
module axi_read_master #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 8,
    parameter int STROBE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    input  logic [2:0]               cmd_size,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic [ADDRESS_WIDTH-1:0] araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     resp_err,
    output logic                     last_err,
    output logic                     size_err
);

    localparam int LW = (STROBE_WIDTH > 1) ? $clog2(STROBE_WIDTH) : 1;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(STROBE_WIDTH));
    localparam logic [LW:0] LANE_ONE = (LW + 1)'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]                  state;
    logic [ADDRESS_WIDTH-1:0]    aligned;
    logic [ADDRESS_WIDTH-1:0]    cur_addr;
    logic [8:0]                  beats_remaining;
    logic [8:0]                  beat_n;
    logic                        beat_fire;
    logic                        first_beat;
    logic                        final_beat;
    logic [LW:0]                 bytes_m1;
    logic [LW:0]                 lower_lane;
    logic [LW:0]                 upper_lane;
    logic [LW:0]                 lane_count;
    logic [DATA_WIDTH-1:0]       shifted;
    logic [DATA_WIDTH-1:0]       beat_data;
    logic [ADDRESS_WIDTH+8:0]    offset;

    assign cmd_ready  = (state == IDLE);
    assign arvalid    = (state == ADDR);
    assign arburst    = 2'b01;
    assign rready     = (state == DATA) && (!out_valid || out_ready);
    assign beat_fire  = rvalid && rready;
    assign first_beat = (beat_n == 9'd1);
    assign final_beat = (beats_remaining == 9'd1);

    // The first beat of an unaligned burst starts mid-word but still
    // ends on the size-aligned boundary.
    assign bytes_m1   = (LANE_ONE << arsize) - LANE_ONE;
    assign lower_lane = {1'b0, cur_addr[LW-1:0]};
    assign upper_lane = first_beat ? {1'b0, aligned[LW-1:0]} + bytes_m1
                                   : lower_lane + bytes_m1;
    assign lane_count = upper_lane - lower_lane + LANE_ONE;
    assign shifted    = rdata >> {lower_lane, 3'b000};
    assign offset     = {{ADDRESS_WIDTH{1'b0}}, beat_n} << arsize;

    always_comb begin
        beat_data = '0;
        for (int i = 0; i < STROBE_WIDTH; i++) begin
            if (i < int'(lane_count))
                beat_data[i*8 +: 8] = shifted[i*8 +: 8];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state           <= IDLE;
            araddr          <= '0;
            arlen           <= '0;
            arsize          <= '0;
            aligned         <= '0;
            cur_addr        <= '0;
            beats_remaining <= '0;
            beat_n          <= '0;
            out_data        <= '0;
            out_valid       <= 1'b0;
            out_last        <= 1'b0;
            resp_err        <= 1'b0;
            last_err        <= 1'b0;
            size_err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_size > MAX_SIZE) begin
                            size_err <= 1'b1;
                        end else begin
                            araddr          <= cmd_addr;
                            arlen           <= cmd_len;
                            arsize          <= cmd_size;
                            aligned         <= (cmd_addr >> cmd_size) << cmd_size;
                            cur_addr        <= cmd_addr;
                            beats_remaining <= {1'b0, cmd_len} + 9'd1;
                            beat_n          <= 9'd1;
                            resp_err        <= 1'b0;
                            last_err        <= 1'b0;
                            size_err        <= 1'b0;
                            state           <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (arready)
                        state <= DATA;
                end
                DATA: begin
                    if (beat_fire) begin
                        beats_remaining <= beats_remaining - 9'd1;
                        beat_n          <= beat_n + 9'd1;
                        cur_addr        <= aligned + offset[ADDRESS_WIDTH-1:0];
                        if (rresp != 2'b00)
                            resp_err <= 1'b1;
                        if (rlast != final_beat)
                            last_err <= 1'b1;
                        if (final_beat)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (beat_fire) begin
                out_data  <= beat_data;
                out_valid <= 1'b1;
                out_last  <= final_beat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_master.sv
// Bench for axi_read_master: byte-addressed RAM slave with random
// handshakes, checked against a byte-level burst model.
module tb_axi_read_master;

    logic        aclk;
    logic        areset;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        resp_err;
    logic        last_err;
    logic        size_err;

    int checks = 0;
    int failures = 0;

    axi_read_master #(
        .DATA_WIDTH(32),
        .ADDRESS_WIDTH(8)
    ) dut (
        .aclk(aclk), .areset(areset),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .out_data(out_data), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .resp_err(resp_err), .last_err(last_err), .size_err(size_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected beat k: bytes from the beat's address up to the next
    // size boundary, RAM byte i holding value i.
    function automatic logic [31:0] exp_beat(int a, int s, int k);
        int bytes = 1 << s;
        int al = a - (a % bytes);
        int start = (k == 0) ? a : al + k * bytes;
        int stop = al + k * bytes + bytes;
        logic [31:0] r = '0;
        for (int j = 0; start + j < stop; j++)
            r[8*j +: 8] = 8'((start + j) % 256);
        return r;
    endfunction

    function automatic logic [31:0] slave_word(int a, int s, int k);
        int bytes = 1 << s;
        int ba = (k == 0) ? a : ((a / bytes) * bytes + k * bytes) % 256;
        int base = (ba / 4) * 4;
        logic [31:0] w;
        for (int l = 0; l < 4; l++)
            w[8*l +: 8] = 8'((base + l) % 256);
        return w;
    endfunction

    task automatic run_burst(input logic [7:0] a, input logic [7:0] l,
                             input logic [2:0] s, input int err_beat,
                             input int flip_beat, input int stall_at,
                             input bit abort);
        int nbeats = int'(l) + 1;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int stall_cnt = 0;
        bit ar_done = 0;
        bit in_data = 0;
        bit ar_hs, r_hs, o_hs;
        logic [7:0] sa = '0;
        logic [2:0] ss = '0;

        @(negedge aclk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
        cmd_valid = 1'b1;
        rvalid    = 1'b0;
        arready   = 1'b0;
        out_ready = 1'b1;
        @(posedge aclk);
        #1 cmd_valid = 1'b0;

        while (got < nbeats) begin
            @(negedge aclk);
            cyc++;
            if (cyc > 3000) begin
                check("timeout", got, nbeats);
                break;
            end
            if (abort && in_data && sent == 1) begin
                areset = 1'b1;
                #1;
                check("rst_arvalid", arvalid, 0);
                check("rst_rready", rready, 0);
                check("rst_out_valid", out_valid, 0);
                check("rst_out_data", out_data, 0);
                check("rst_cmd_ready", cmd_ready, 1);
                @(negedge aclk);
                areset = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    rvalid = 1'b1;
                    rdata = $urandom;
                    out_ready = 1'b1;
                    @(negedge aclk);
                    check("post_rst_out_valid", out_valid, 0);
                    check("post_rst_arvalid", arvalid, 0);
                    check("post_rst_rready", rready, 0);
                end
                rvalid = 1'b0;
                return;
            end

            arready = 1'($urandom_range(0, 1));
            if (in_data && sent < nbeats) begin
                rvalid = ($urandom_range(0, 3) != 0);
                rdata  = slave_word(int'(sa), int'(ss), sent);
                rresp  = (sent == err_beat) ? 2'b10 : 2'b00;
                rlast  = (sent == nbeats - 1) ^ (sent == flip_beat);
            end else begin
                rvalid = 1'($urandom_range(0, 1));
                rdata  = $urandom;
                rresp  = 2'($urandom_range(0, 3));
                rlast  = 1'($urandom_range(0, 1));
            end
            if (stall_at >= 0 && got == stall_at && stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            #1;
            check("rready", rready, in_data && (!out_valid || out_ready));
            check("arvalid", arvalid, !ar_done);
            ar_hs = arvalid && arready && !ar_done;
            if (ar_hs) begin
                check("araddr", araddr, a);
                check("arlen", arlen, l);
                check("arsize", arsize, s);
                check("arburst", arburst, 2'b01);
                sa = araddr;
                ss = arsize;
            end
            r_hs = rvalid && rready;
            o_hs = out_valid && out_ready;
            if (o_hs) begin
                check("out_data", out_data, exp_beat(int'(a), int'(s), got));
                check("out_last", out_last, got == nbeats - 1);
                got++;
            end
            @(posedge aclk);
            if (ar_hs) begin
                ar_done = 1;
                in_data = 1;
            end
            if (r_hs) begin
                sent++;
                if (sent == nbeats)
                    in_data = 0;
            end
        end

        @(negedge aclk);
        rvalid = 1'b0;
        check("drained_out_valid", out_valid, 0);
        check("resp_err", resp_err, err_beat >= 0 && err_beat < nbeats);
        check("last_err", last_err, flip_beat >= 0 && flip_beat < nbeats);
        check("size_err", size_err, 0);
    endtask

    task automatic bad_size();
        @(negedge aclk);
        cmd_addr  = 8'h20;
        cmd_len   = 8'd3;
        cmd_size  = 3'd3;
        cmd_valid = 1'b1;
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
        check("size_err_set", size_err, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            check("size_arvalid", arvalid, 0);
            check("size_cmd_ready", cmd_ready, 1);
        end
    endtask

    initial begin
        areset    = 1'b1;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_size  = '0;
        cmd_valid = 1'b0;
        arready   = 1'b0;
        rdata     = '0;
        rresp     = '0;
        rlast     = 1'b0;
        rvalid    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_arvalid", arvalid, 0);
        check("reset_rready", rready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_last", out_last, 0);
        check("reset_out_data", out_data, 0);
        check("reset_flags", {resp_err, last_err, size_err}, 0);
        check("reset_ar", {araddr, arlen, arsize}, 0);
        areset = 1'b0;

        run_burst(8'h10, 8'd3, 3'd2, -1, -1, -1, 0);
        run_burst(8'h06, 8'd1, 3'd2, -1, -1, -1, 0);
        run_burst(8'h05, 8'd1, 3'd0, -1, -1, -1, 0);
        run_burst(8'h10, 8'd3, 3'd2, -1, -1, 1, 0);
        run_burst(8'h10, 8'd3, 3'd2, 1, 2, -1, 0);
        run_burst(8'h10, 8'd3, 3'd2, -1, -1, -1, 0);
        run_burst(8'hF6, 8'd5, 3'd2, -1, -1, -1, 0);
        run_burst(8'h10, 8'd3, 3'd2, -1, -1, -1, 1);
        bad_size();
        run_burst(8'h33, 8'd2, 3'd1, -1, -1, -1, 0);

        for (int t = 0; t < 40; t++) begin
            logic [7:0] ra, rl;
            logic [2:0] rs;
            int eb, fb, st;
            ra = 8'($urandom);
            rl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40))
                                             : 8'($urandom_range(0, 7));
            rs = 3'($urandom_range(0, 2));
            eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(rl)) : -1;
            fb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(rl)) : -1;
            st = ($urandom_range(0, 1) == 0) ? $urandom_range(0, int'(rl)) : -1;
            run_burst(ra, rl, rs, eb, fb, st, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
